// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable clock divider with boundary-aligned reload
module clk_divider_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 20,
  parameter int DEF_HIGH = 10
) (
  input  logic                      I_CLK,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       I_EN,
  input  logic [CHANNELS-1:0]       I_LOAD,
  input  logic [CHANNELS*CNT_W-1:0] I_DIV,
  input  logic [CHANNELS*CNT_W-1:0] I_HIGH,
  input  logic                      I_SYNC,
  output logic [CHANNELS-1:0]       O_CLK,
  output logic [CHANNELS-1:0]       O_TICK
);

  // Period must be at least 2 so both phases exist.
  function automatic logic [CNT_W-1:0] san_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // High time is clamped into [1, div-1] against the already-sanitised period.
  function automatic logic [CNT_W-1:0] san_high(input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] d);
    if (h == '0)     return CNT_W'(1);
    else if (h >= d) return d - CNT_W'(1);
    else             return h;
  endfunction

  // Per-channel state: counter, active settings, shadow settings.
  logic [CNT_W-1:0] cnt    [CHANNELS];
  logic [CNT_W-1:0] div_q  [CHANNELS];
  logic [CNT_W-1:0] high_q [CHANNELS];
  logic [CNT_W-1:0] div_s  [CHANNELS];
  logic [CNT_W-1:0] high_s [CHANNELS];
  logic [CHANNELS-1:0] run;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] clk_r;
  logic [CHANNELS-1:0] tick_r;

  logic [CNT_W-1:0] cnt_nx    [CHANNELS];
  logic [CNT_W-1:0] div_q_nx  [CHANNELS];
  logic [CNT_W-1:0] high_q_nx [CHANNELS];
  logic [CNT_W-1:0] div_s_nx  [CHANNELS];
  logic [CNT_W-1:0] high_s_nx [CHANNELS];
  logic [CHANNELS-1:0] run_nx;
  logic [CHANNELS-1:0] pend_nx;
  logic [CHANNELS-1:0] clk_nx;
  logic [CHANNELS-1:0] tick_nx;
  logic [CHANNELS-1:0] apply;

  // Sanitised view of the requested slice, used whenever a load strobe is seen.
  logic [CNT_W-1:0] ld_div  [CHANNELS];
  logic [CNT_W-1:0] ld_high [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_san
    assign ld_div[g]  = san_div(I_DIV[g*CNT_W +: CNT_W]);
    assign ld_high[g] = san_high(I_HIGH[g*CNT_W +: CNT_W], ld_div[g]);
  end

  // State register for every channel; reset restores the default settings.
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt[k]    <= '0;
        div_q[k]  <= CNT_W'(DEF_DIV);
        high_q[k] <= CNT_W'(DEF_HIGH);
        div_s[k]  <= CNT_W'(DEF_DIV);
        high_s[k] <= CNT_W'(DEF_HIGH);
      end
      run    <= '0;
      pend   <= '0;
      clk_r  <= '0;
      tick_r <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt[k]    <= cnt_nx[k];
        div_q[k]  <= div_q_nx[k];
        high_q[k] <= high_q_nx[k];
        div_s[k]  <= div_s_nx[k];
        high_s[k] <= high_s_nx[k];
      end
      run    <= run_nx;
      pend   <= pend_nx;
      clk_r  <= clk_nx;
      tick_r <= tick_nx;
    end
  end

  // Next-state: disable beats sync beats wrap beats increment; settings swap only at boundaries.
  always_comb begin
    run_nx  = run;
    pend_nx = pend;
    clk_nx  = clk_r;
    tick_nx = '0;
    apply   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cnt_nx[k]    = cnt[k];
      div_q_nx[k]  = div_q[k];
      high_q_nx[k] = high_q[k];
      div_s_nx[k]  = I_LOAD[k] ? ld_div[k]  : div_s[k];
      high_s_nx[k] = I_LOAD[k] ? ld_high[k] : high_s[k];
      pend_nx[k]   = pend[k] | I_LOAD[k];

      if (!run[k]) begin
        // Idle: pending settings go live at once; enable starts a period.
        apply[k]  = pend[k] | I_LOAD[k];
        cnt_nx[k] = '0;
        if (I_EN[k]) begin
          run_nx[k]  = 1'b1;
          clk_nx[k]  = 1'b1;
          tick_nx[k] = 1'b1;
        end else begin
          clk_nx[k] = 1'b0;
        end
      end else if (!I_EN[k]) begin
        // Abrupt stop; the current period is abandoned.
        run_nx[k] = 1'b0;
        cnt_nx[k] = '0;
        clk_nx[k] = 1'b0;
      end else if (I_SYNC || (cnt[k] == div_q[k] - CNT_W'(1))) begin
        apply[k]   = pend[k] | I_LOAD[k];
        cnt_nx[k]  = '0;
        clk_nx[k]  = 1'b1;
        tick_nx[k] = 1'b1;
      end else begin
        cnt_nx[k] = cnt[k] + CNT_W'(1);
        clk_nx[k] = (cnt[k] + CNT_W'(1)) < high_q[k];
      end

      if (apply[k]) begin
        div_q_nx[k]  = div_s_nx[k];
        high_q_nx[k] = high_s_nx[k];
        pend_nx[k]   = 1'b0;
      end
    end
  end

  // Outputs come straight from registers so they are glitch-free.
  always_comb begin
    O_CLK  = clk_r;
    O_TICK = tick_r;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - directed self-checking bench for clk_divider_multi
module tb_clk_divider_multi;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          I_CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] I_EN;
  logic [CH-1:0] I_LOAD;
  logic [CH*W-1:0] I_DIV;
  logic [CH*W-1:0] I_HIGH;
  logic          I_SYNC;
  logic [CH-1:0] O_CLK;
  logic [CH-1:0] O_TICK;

  clk_divider_multi #(
    .CHANNELS(CH), .CNT_W(W), .DEF_DIV(20), .DEF_HIGH(10)
  ) dut (
    .I_CLK(I_CLK), .rst_n(rst_n), .I_EN(I_EN), .I_LOAD(I_LOAD),
    .I_DIV(I_DIV), .I_HIGH(I_HIGH), .I_SYNC(I_SYNC),
    .O_CLK(O_CLK), .O_TICK(O_TICK)
  );

  always #5 I_CLK = ~I_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each channel tracks the cycles elapsed since its period began.
  int m_run [CH];
  int m_ph  [CH];
  int m_div [CH];
  int m_high[CH];
  int m_sdiv[CH];
  int m_shigh[CH];
  int m_pend[CH];
  int md, mh, mbnd;
  logic [CH-1:0] exp_clk;
  logic [CH-1:0] exp_tick;

  always @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        m_run[k] = 0; m_ph[k] = 0; m_pend[k] = 0;
        m_div[k] = 20; m_high[k] = 10; m_sdiv[k] = 20; m_shigh[k] = 10;
      end
      exp_clk  = '0;
      exp_tick = '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (I_LOAD[k]) begin
          md = int'(I_DIV[k*W +: W]);
          mh = int'(I_HIGH[k*W +: W]);
          if (md < 2) md = 2;
          if (mh < 1) mh = 1;
          if (mh > md - 1) mh = md - 1;
          m_sdiv[k] = md; m_shigh[k] = mh; m_pend[k] = 1;
        end
        mbnd = 0;
        if (m_run[k] == 0) begin
          if (I_EN[k]) begin m_run[k] = 1; mbnd = 1; end
          else if (m_pend[k] != 0) begin
            m_div[k] = m_sdiv[k]; m_high[k] = m_shigh[k]; m_pend[k] = 0;
          end
        end else if (!I_EN[k]) begin
          m_run[k] = 0; m_ph[k] = 0;
        end else if (I_SYNC || (m_ph[k] + 1 == m_div[k])) begin
          mbnd = 1;
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
        if (mbnd != 0) begin
          if (m_pend[k] != 0) begin
            m_div[k] = m_sdiv[k]; m_high[k] = m_shigh[k]; m_pend[k] = 0;
          end
          m_ph[k] = 0;
        end
        exp_clk[k]  = (m_run[k] != 0) && (m_ph[k] < m_high[k]);
        exp_tick[k] = (mbnd != 0);
      end
    end
  end

  logic [63:0] pat [CH];
  int          ticks[CH];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: outputs are compared to the model on the falling edge, then recorded.
  task automatic cyc();
    @(posedge I_CLK);
    @(negedge I_CLK);
    chk("o_clk_vs_model", 64'(O_CLK), 64'(exp_clk));
    chk("o_tick_vs_model", 64'(O_TICK), 64'(exp_tick));
    for (int k = 0; k < CH; k++) begin
      pat[k]   = {pat[k][62:0], O_CLK[k]};
      ticks[k] = ticks[k] + int'(O_TICK[k]);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < CH; k++) begin
      pat[k]   = '0;
      ticks[k] = 0;
    end
  endtask

  task automatic set_ch(input int k, input int d, input int h);
    I_DIV[k*W +: W]  = W'(d);
    I_HIGH[k*W +: W] = W'(h);
  endtask

  initial begin
    I_EN = '0; I_LOAD = '0; I_DIV = '0; I_HIGH = '0; I_SYNC = 1'b0;
    clr();
    cyc(); cyc();
    chk("reset_clk", 64'(O_CLK), 64'h0);
    chk("reset_tick", 64'(O_TICK), 64'h0);
    rst_n = 1'b1;
    cyc();

    // Default 20/10 on channel 0 from the enable edge.
    clr(); I_EN = 4'b0001;
    repeat (40) cyc();
    chk("ch0_default_pattern", pat[0][39:0], 64'hFF_C00F_FC00);
    chk("ch0_default_ticks", 64'(ticks[0]), 64'd2);
    chk("ch123_idle", pat[1] | pat[2] | pat[3], 64'h0);

    // Channel 1 programmed while idle, then a degenerate load landing on a wrap edge.
    set_ch(1, 5, 2); I_LOAD = 4'b0010; cyc(); I_LOAD = '0;
    clr(); I_EN = 4'b0011;
    repeat (10) cyc();
    chk("ch1_5_2_pattern", pat[1][9:0], 64'b1100011000);
    set_ch(1, 0, 0); I_LOAD = 4'b0010; clr(); cyc(); I_LOAD = '0;
    repeat (5) cyc();
    chk("ch1_sanitised_2_1", pat[1][5:0], 64'b101010);

    // Channel 0 restarted; two loads mid-period, only the second lands at the wrap.
    I_EN = 4'b0010; cyc();
    clr(); I_EN = 4'b0011;
    repeat (4) cyc();
    set_ch(0, 9, 4); I_LOAD = 4'b0001; cyc();
    set_ch(0, 6, 3); cyc(); I_LOAD = '0;
    repeat (20) cyc();
    chk("ch0_reload_at_wrap", pat[0][25:0], 64'b11111111110000000000111000);
    chk("ch0_reload_ticks", 64'(ticks[0]), 64'd2);

    // Channels 2 and 3 out of phase, then realigned by sync.
    set_ch(2, 7, 3); set_ch(3, 9, 4); I_LOAD = 4'b1100; cyc(); I_LOAD = '0;
    I_EN = 4'b0111; repeat (3) cyc();
    I_EN = 4'b1111; repeat (5) cyc();
    I_SYNC = 1'b1; cyc(); I_SYNC = 1'b0;
    chk("sync_clk_ch23", 64'(O_CLK[3:2]), 64'b11);
    chk("sync_tick_ch23", 64'(O_TICK[3:2]), 64'b11);
    repeat (7) cyc();
    chk("ch2_tick_after_sync", 64'(O_TICK[3:2]), 64'b01);
    repeat (2) cyc();
    chk("ch3_tick_after_sync", 64'(O_TICK[3:2]), 64'b10);

    // Drop channel 0 mid-high, then re-enable for a full high phase.
    I_SYNC = 1'b1; cyc(); I_SYNC = 1'b0;
    cyc();
    chk("ch0_high_before_drop", 64'(O_CLK[0]), 64'd1);
    I_EN = 4'b1110; cyc();
    chk("ch0_drop_low", 64'(O_CLK[0]), 64'd0);
    I_EN = 4'b1111; clr();
    repeat (6) cyc();
    chk("ch0_reenable_pattern", pat[0][5:0], 64'b111000);

    // Asynchronous reset between edges, then defaults again.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk", 64'(O_CLK), 64'h0);
    chk("async_rst_tick", 64'(O_TICK), 64'h0);
    I_EN = 4'b0001;
    cyc();
    rst_n = 1'b1; clr();
    repeat (20) cyc();
    chk("revert_default_pattern", pat[0][19:0], 64'hFFC00);
    chk("revert_others_idle", pat[1] | pat[2] | pat[3], 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
